// File: rtl/nibble_log_pkg.sv
// Purpose: shared constants and types for the nibble change logger.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   NIB_W     : width of the observed result bus.
//   LOG_DEPTH : default number of log entries.
//   LOG_TS_W  : default timestamp width.
//   nib_t     : one result-bus sample.
package nibble_log_pkg;

    localparam int NIB_W     = 4;
    localparam int LOG_DEPTH = 4;
    localparam int LOG_TS_W  = 8;

    typedef logic [NIB_W-1:0] nib_t;

endpackage : nibble_log_pkg

// File: rtl/nibble_log_fifo.sv
// Purpose: first-word-fall-through log buffer of {data, ts} entries with drop-on-full.
// Latency: a push at edge N is visible at the head right after edge N; the head is read straight from storage.
// Backpressure: head held while out_ready=0; a push into a full buffer is dropped unless a pop frees a slot in the same cycle.
//   clk, rst             : clock, synchronous active-high reset
//   push, push_data/ts   : write request and entry fields
//   out_valid/ready      : head handshake; out_data/out_ts present the head entry
//   count                : entries held
//   overflow             : sticky, set when a push was dropped; cleared only by rst
module nibble_log_fifo
    import nibble_log_pkg::*;
#(
    parameter int DEPTH = LOG_DEPTH,
    parameter int TS_W  = LOG_TS_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [NIB_W-1:0]             push_data,
    input  logic [TS_W-1:0]              push_ts,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIB_W-1:0]             out_data,
    output logic [TS_W-1:0]              out_ts,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    nib_t              mem_data [DEPTH];
    logic [TS_W-1:0]   mem_ts   [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;

    logic              empty;
    logic              full;
    logic              pop;
    logic              do_push;
    logic              drop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // A simultaneous pop frees the slot this push needs, so a full buffer
    // still accepts the entry in that case.
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign out_data = mem_data[rptr[AW-1:0]];
    assign out_ts   = mem_ts[rptr[AW-1:0]];
    assign count    = CW'(wptr - rptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            // Storage is cleared so the head reads as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_ts[i]   <= '0;
            end
        end else begin
            if (do_push) begin
                mem_data[wptr[AW-1:0]] <= push_data;
                mem_ts[wptr[AW-1:0]]   <= push_ts;
                wptr                   <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule : nibble_log_fifo

// File: rtl/nibble_change_logger.sv
// Purpose: samples the 4-bit result bus, logs each value change with a free-running cycle stamp.
// Latency: a change sampled at edge N is at the log head right after edge N, stamped with ts from before edge N.
// Backpressure: out_valid/out_ready drain; a full log drops new changes and sets the sticky overflow flag.
//   clk, rst        : clock, synchronous active-high reset
//   in_en, in       : sample qualifier and result value
//   out_valid/ready : log head handshake; out_data/out_ts give the head entry
//   count           : entries held; overflow: a change was dropped since reset
module nibble_change_logger
    import nibble_log_pkg::*;
#(
    parameter int DEPTH = LOG_DEPTH,
    parameter int TS_W  = LOG_TS_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_en,
    input  logic [NIB_W-1:0]             in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIB_W-1:0]             out_data,
    output logic [TS_W-1:0]              out_ts,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    logic [TS_W-1:0] ts;
    nib_t            prev;
    logic            prev_vld;
    logic            change;

    // Free-running stamp; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // prev_vld is cleared by reset so the first enabled sample afterwards is
    // always treated as a change, whatever value it carries.
    assign change = in_en && (!prev_vld || (in != prev));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            prev_vld <= 1'b0;
        end else if (in_en) begin
            prev     <= in;
            prev_vld <= 1'b1;
        end
    end

    nibble_log_fifo #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (change),
        .push_data (in),
        .push_ts   (ts),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .count     (count),
        .overflow  (overflow)
    );

endmodule : nibble_change_logger

// File: doc/nibble_change_logger.md
# nibble_change_logger

Downstream consumer of the 4-bit result stage. Samples a 4-bit result bus each clock when enabled and detects value changes. Each change is logged with a free-running cycle timestamp into a small first-word-fall-through buffer. A valid/ready port drains the log to a monitor or scoreboard, giving a synthesizable, cycle-stamped record of result-bus activity.

## Interface
- `DEPTH`, default 4: log entries; power of two, ≥2.
- `TS_W`, default 8: timestamp width in bits.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: reset; synchronous, active-high.
- `in_en`  in  1: sample qualifier for `in`.
- `in`  in  4: result value from the upstream stage.
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_data`  out  4: head entry value.
- `out_ts`  out  TS_W: head entry timestamp.
- `count`  out  $clog2(DEPTH+1): entries held.
- `overflow`  out  1: sticky flag; a change was dropped.

## Operation
- Timestamp counter `ts`:
  - Cleared by `rst`.
  - Increments by 1 every cycle.
  - Wraps modulo 2^TS_W with no flag.
- Change detect:
  - Holds `prev` (4 b) and `prev_vld` (1 b).
  - Change = `in_en && (!prev_vld || in != prev)`.
  - When `in_en` is high: `prev <= in`, `prev_vld <= 1`.
  - When `in_en` is low: `prev` and `prev_vld` hold.
- Push: on a change, write {`in`, `ts` of the same cycle} at the tail.
- Pop: occurs when `out_valid && out_ready`; the head advances.
  - `out_ready` while empty has no effect.
- Full:
  - Push without a simultaneous pop: entry dropped, `overflow <= 1`, buffer unchanged.
  - Push with a simultaneous pop: both occur, `count` unchanged, no overflow.
- Empty with push and `out_ready` in the same cycle: the entry is written; no pop that cycle.
- `overflow` clears only on `rst`.
- `out_data`/`out_ts` are don't-care while `out_valid` is 0. The bench checks them only when valid.
- Reset mid-operation: all entries discarded, and `prev_vld` is cleared. The first enabled sample after reset is therefore always logged.

## Timing
- Reset values:
  - `out_valid` = 0, `count` = 0, `overflow` = 0.
  - `out_data` = 0, `out_ts` = 0.
  - `ts` = 0, `prev` = 0, `prev_vld` = 0.
- Latency: a change sampled at edge N gives `out_valid` = 1 after edge N, with `out_data`/`out_ts` valid in the same cycle. The stored `ts` is the value present before edge N.
- `ts` = k in the k-th cycle after `rst` deasserts (first cycle k = 0).
- FWFT: the head is presented combinationally from storage; there is no pop-to-data bubble.
- Throughput: one push and one pop per cycle.
- `count` and `overflow` update at the edge that performs the push/pop/drop.
- The valid/ready rule is standard: while `out_valid` = 1 and `out_ready` = 0, the head entry is held stable.

## Structure
- Package `nibble_log_pkg`:
  - `NIB_W` = 4.
  - Default constants `LOG_DEPTH` = 4 and `LOG_TS_W` = 8.
  - `nib_t` typedef (`logic [NIB_W-1:0]`).
- One sub-module, `nibble_log_fifo`:
  - Parameterized FWFT FIFO of {data, ts} entries.
  - Read/write pointers with a wrap bit; full/empty derived from the pointers.
  - Drop-on-full and the `overflow` flag.
- The top level holds the `ts` counter, the change detector, and the sub-module instance.

## Test plan
- Reset, then hold `in_en` = 0 for 5 cycles -> `out_valid` = 0, `count` = 0, `overflow` = 0 throughout.
- Changing values with `out_ready` = 0:
  - Stimulus: from `ts` = 2, `in_en` = 1; `in` sequence 3,3,5,5,5,9.
  - Required: three entries {3,2}, {5,4}, {9,7}; `count` = 3.
  - Then raise `out_ready`: entries pop in that order over 3 cycles, then `out_valid` = 0.
- Overflow, DEPTH = 4, `out_ready` = 0:
  - Stimulus: log 1,2,3,4,5 on consecutive cycles.
  - Required: `count` = 4, `overflow` = 1, entry 5 absent.
  - Draining returns 1,2,3,4 only.
- Full with simultaneous pop:
  - Stimulus: with 4 entries held, push value 7 with `out_ready` = 1.
  - Required: `count` stays 4, `overflow` = 0, 7 is the last entry drained.
- Reset mid-stream and wrap:
  - Stimulus: hold `in` = 6 with `in_en` = 1; pulse `rst` for one cycle.
  - Required: `count` = 0; 6 is logged again with `ts` = 0.
  - Run 256 cycles with TS_W = 8: `ts` wraps 255 -> 0, and a change at wrap is logged with `out_ts` = 0.
